// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the fetcher and memory controller use the master modport.
interface icache_direct_if;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        flush;
   logic        fetch_ready;
   logic        ins_valid;
   logic [31:0] ins;
   logic [31:0] pc_in;
   logic        pc_miss_sgn;
   logic        finish_ins;
   logic [511:0] ins_out;

   modport slave (
      input  fetch_req, fetch_pc, flush, finish_ins, ins_out,
      output fetch_ready, ins_valid, ins, pc_in, pc_miss_sgn
   );

   modport master (
      output fetch_req, fetch_pc, flush, finish_ins, ins_out,
      input  fetch_ready, ins_valid, ins, pc_in, pc_miss_sgn
   );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: 2^INDEX_BITS lines of 64 B, single outstanding line refill.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counter outputs.
module icache_direct #(
   parameter int INDEX_BITS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   icache_direct_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 26 - INDEX_BITS;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t                  state;
   logic                    killed;
   logic [3:0]              miss_off;
   logic [LINES-1:0]        valid_bits;
   logic [TAG_W-1:0]        tag_mem  [LINES];
   logic [511:0]            data_mem [LINES];

   logic [INDEX_BITS-1:0]   req_idx;
   logic [TAG_W-1:0]        req_tag;
   logic [3:0]              req_off;
   logic [INDEX_BITS-1:0]   fill_idx;
   logic [TAG_W-1:0]        fill_tag;
   logic                    hit;
   logic                    accept;
   logic                    fill_done;
   logic                    unused_pc_bits;

   assign req_off        = bus.fetch_pc[5:2];
   assign req_idx        = bus.fetch_pc[5+INDEX_BITS:6];
   assign req_tag        = bus.fetch_pc[31:6+INDEX_BITS];
   assign fill_idx       = bus.pc_in[5+INDEX_BITS:6];
   assign fill_tag       = bus.pc_in[31:6+INDEX_BITS];
   assign unused_pc_bits = ^bus.fetch_pc[1:0];

   assign hit       = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
   assign accept    = (state == IDLE) && bus.fetch_req && !bus.flush;
   assign fill_done = (state == REFILL) && bus.finish_ins;

   // NOTE: line data and tags carry no reset; the cleared valid bits make their contents irrelevant.
   always_ff @(posedge clk) begin
      if (rdy && fill_done) begin
         data_mem[fill_idx] <= bus.ins_out;
         tag_mem[fill_idx]  <= fill_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         killed          <= 1'b0;
         miss_off        <= '0;
         valid_bits      <= '0;
         bus.fetch_ready <= 1'b1;
         bus.ins_valid   <= 1'b0;
         bus.ins         <= '0;
         bus.pc_in       <= '0;
         bus.pc_miss_sgn <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
         hit_cnt         <= '0;
         miss_cnt        <= '0;
`endif
      end else if (rdy) begin
         // ins_valid is a one-cycle pulse; it only clears on an enabled edge so a stall holds it.
         bus.ins_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     bus.ins       <= data_mem[req_idx][{req_off, 5'b0} +: 32];
                     bus.ins_valid <= 1'b1;
`ifdef ICACHE_PERF_CNT_EN
                     hit_cnt       <= hit_cnt + 32'd1;
`endif
                  end else begin
                     state           <= REFILL;
                     killed          <= 1'b0;
                     miss_off        <= req_off;
                     bus.pc_in       <= {bus.fetch_pc[31:6], 6'b0};
                     bus.pc_miss_sgn <= 1'b1;
                     bus.fetch_ready <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
                     miss_cnt        <= miss_cnt + 32'd1;
`endif
                  end
               end
            end
            REFILL: begin
               if (bus.finish_ins) begin
                  // The requested word is bypassed from the incoming line, not re-read from storage.
                  valid_bits[fill_idx] <= 1'b1;
                  bus.ins              <= bus.ins_out[{miss_off, 5'b0} +: 32];
                  bus.ins_valid        <= !(killed || bus.flush);
                  bus.pc_miss_sgn      <= 1'b0;
                  bus.fetch_ready      <= 1'b1;
                  killed               <= 1'b0;
                  state                <= IDLE;
               end else if (bus.flush) begin
                  killed <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct (default build, INDEX_BITS=4).
`timescale 1ns/1ps
module tb_icache_direct;

   logic clk;
   logic rst;
   logic rdy;
   int   checks;
   int   errors;

   icache_direct_if bus ();

   icache_direct #(.INDEX_BITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory contents: word k of the line at address a.
   function automatic logic [31:0] word_of(input logic [31:0] a, input int k);
      logic [31:0] kk;
      kk = k;
      if (a == 32'h0000_1040 && k == 1) return 32'hDEAD_BEEF;
      return a ^ (kk << 2) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [511:0] mk_line(input logic [31:0] a);
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = word_of(a, k);
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      bus.fetch_pc  = pc;
      bus.fetch_req = 1'b1;
      tick();
      bus.fetch_req = 1'b0;
   endtask

   // Memory controller response for line a, optionally flushing on the completion edge.
   task automatic finish(input logic [31:0] a, input logic with_flush);
      bus.ins_out    = mk_line(a);
      bus.finish_ins = 1'b1;
      bus.flush      = with_flush;
      tick();
      bus.finish_ins = 1'b0;
      bus.flush      = 1'b0;
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b0;
      rdy            = 1'b1;
      bus.fetch_req  = 1'b0;
      bus.fetch_pc   = '0;
      bus.flush      = 1'b0;
      bus.finish_ins = 1'b0;
      bus.ins_out    = '0;

      // Reset values
      #12;
      check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
      check("rst_ins_valid",   32'(bus.ins_valid),   32'd0);
      check("rst_ins",         bus.ins,              32'd0);
      check("rst_pc_in",       bus.pc_in,            32'd0);
      check("rst_miss",        32'(bus.pc_miss_sgn), 32'd0);
      rst = 1'b1;
      tick();

      // Cold miss
      fetch(32'h0000_1044);
      check("cold_miss_sgn",   32'(bus.pc_miss_sgn), 32'd1);
      check("cold_pc_in",      bus.pc_in,            32'h0000_1040);
      check("cold_not_ready",  32'(bus.fetch_ready), 32'd0);
      bus.fetch_pc = 32'h0000_9999;
      tick();
      tick();
      check("cold_pc_in_held", bus.pc_in,            32'h0000_1040);
      check("cold_miss_held",  32'(bus.pc_miss_sgn), 32'd1);
      finish(32'h0000_1040, 1'b0);
      check("cold_ins_valid",  32'(bus.ins_valid),   32'd1);
      check("cold_ins",        bus.ins,              32'hDEAD_BEEF);
      check("cold_miss_low",   32'(bus.pc_miss_sgn), 32'd0);
      check("cold_ready",      32'(bus.fetch_ready), 32'd1);
      tick();
      check("cold_pulse_end",  32'(bus.ins_valid),   32'd0);

      // Hit streaming, one request per cycle
      for (int i = 0; i < 16; i++) begin
         bus.fetch_pc  = 32'h0000_1040 + 32'(4 * i);
         bus.fetch_req = 1'b1;
         tick();
         check($sformatf("stream_valid_%0d", i), 32'(bus.ins_valid),   32'd1);
         check($sformatf("stream_ins_%0d", i),   bus.ins,              word_of(32'h0000_1040, i));
         check($sformatf("stream_miss_%0d", i),  32'(bus.pc_miss_sgn), 32'd0);
      end
      bus.fetch_req = 1'b0;
      tick();
      check("stream_end", 32'(bus.ins_valid), 32'd0);

      // finish_ins outside REFILL is ignored
      bus.ins_out    = '1;
      bus.finish_ins = 1'b1;
      tick();
      bus.finish_ins = 1'b0;
      check("stray_finish_valid", 32'(bus.ins_valid), 32'd0);
      fetch(32'h0000_1048);
      check("stray_finish_hit", bus.ins, word_of(32'h0000_1040, 2));

      // Conflict eviction: 0x1440 shares index 1 with 0x1040
      fetch(32'h0000_1440);
      check("conf_miss",  32'(bus.pc_miss_sgn), 32'd1);
      check("conf_pc_in", bus.pc_in,            32'h0000_1440);
      finish(32'h0000_1440, 1'b0);
      check("conf_ins",   bus.ins,              word_of(32'h0000_1440, 0));
      fetch(32'h0000_1040);
      check("conf_remiss", 32'(bus.pc_miss_sgn), 32'd1);
      check("conf_remiss_valid", 32'(bus.ins_valid), 32'd0);
      finish(32'h0000_1040, 1'b0);
      check("conf_refill_ins", bus.ins, word_of(32'h0000_1040, 0));

      // Flush during refill
      fetch(32'h0000_2000);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      finish(32'h0000_2000, 1'b0);
      check("flush_no_valid", 32'(bus.ins_valid),   32'd0);
      check("flush_ready",    32'(bus.fetch_ready), 32'd1);
      fetch(32'h0000_2004);
      check("flush_hit_valid", 32'(bus.ins_valid), 32'd1);
      check("flush_hit_ins",   bus.ins,            word_of(32'h0000_2000, 1));

      // Flush in IDLE drops a same-edge hit
      bus.flush = 1'b1;
      fetch(32'h0000_2008);
      bus.flush = 1'b0;
      check("idle_flush_drop", 32'(bus.ins_valid), 32'd0);

      // Flush and finish_ins on the same edge: installed, no ins_valid
      fetch(32'h0000_3000);
      tick();
      finish(32'h0000_3000, 1'b1);
      check("same_edge_no_valid", 32'(bus.ins_valid), 32'd0);
      fetch(32'h0000_3008);
      check("same_edge_hit", bus.ins, word_of(32'h0000_3000, 2));
      check("same_edge_hit_valid", 32'(bus.ins_valid), 32'd1);

      // Async reset two cycles into REFILL
      fetch(32'h0000_4000);
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      check("arst_miss_low", 32'(bus.pc_miss_sgn), 32'd0);
      check("arst_ready",    32'(bus.fetch_ready), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      fetch(32'h0000_1040);
      check("arst_remiss", 32'(bus.pc_miss_sgn), 32'd1);
      finish(32'h0000_1040, 1'b0);
      check("arst_refill_ins", bus.ins, word_of(32'h0000_1040, 0));

      // rdy stall with a hit pulse outstanding
      fetch(32'h0000_104C);
      rdy = 1'b0;
      bus.fetch_pc  = 32'h0000_5000;
      bus.fetch_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall_valid_%0d", i), 32'(bus.ins_valid),   32'd1);
         check($sformatf("stall_ins_%0d", i),   bus.ins,              word_of(32'h0000_1040, 3));
         check($sformatf("stall_miss_%0d", i),  32'(bus.pc_miss_sgn), 32'd0);
      end
      bus.fetch_req = 1'b0;
      rdy = 1'b1;
      tick();
      check("stall_done", 32'(bus.ins_valid), 32'd0);
      fetch(32'h0000_1050);
      check("stall_after_hit", bus.ins, word_of(32'h0000_1040, 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped instruction cache between the instruction fetcher and the memory controller. It serves 32-bit instruction reads from fetch. On a miss it raises a line-refill request to the memory controller. It then waits for the 64-byte (16-instruction) line, installs it, and returns the requested instruction.

## Interface
Parameters:
- INDEX_BITS, 4, log2 of line count (default 16 lines × 64 B = 1 KiB); tag width = 26 − INDEX_BITS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset; all state cleared while low
- rdy  in  1  global enable; when low all state and outputs hold
- fetch_req  in  1  fetch request valid
- fetch_pc  in  32  instruction address (bits [1:0] ignored)
- flush  in  1  discard outstanding fetch (branch redirect)
- fetch_ready  out  1  high when a request can be accepted (state IDLE)
- ins_valid  out  1  one-cycle pulse: ins holds requested instruction
- ins  out  32  instruction word
- pc_in  out  32  refill line address {pc[31:6],6'b0} to memory controller
- pc_miss_sgn  out  1  refill request, level, held until finish_ins
- finish_ins  in  1  one-cycle pulse: refill line complete on ins_out
- ins_out  in  512  refill line; byte i = mem[line+i], word k = ins_out[32k+31:32k]

## Operation
- Address split: offset = pc[5:2] (word), index = pc[5+INDEX_BITS:6], tag = pc[31:6+INDEX_BITS].
- Storage: per line valid bit, tag, 512-bit data; all valid bits cleared on reset.
- States:
  - IDLE: fetch_ready=1.
  - REFILL: fetch_ready=0, pc_miss_sgn=1.
- IDLE, fetch_req && !flush sampled:
  - Hit (valid && tag match): register ins = line word[offset]; assert ins_valid next cycle; stay IDLE.
  - Miss: latch pc, drive pc_in, go to REFILL.
- REFILL, finish_ins sampled:
  - Write ins_out into data[index]; set tag; set valid.
  - Register ins = ins_out word[offset] (bypass, not a re-read).
  - Assert ins_valid next cycle unless the request was killed; go to IDLE.
- flush:
  - Sampled in IDLE: drops any request sampled on the same edge; no ins_valid follows.
  - Sampled in REFILL: marks the request killed; the refill still completes and the line is still installed (memory transaction cannot be aborted); ins_valid is suppressed.
- fetch_req while fetch_ready=0 is ignored; the fetcher must re-present it.

## Timing
- Reset values: fetch_ready=1, ins_valid=0, ins=0, pc_in=0, pc_miss_sgn=0, all valid bits 0.
- Hit latency: request sampled at edge N → ins_valid high N+1 → N+2. Back-to-back hits every cycle.
- Miss: sampled at edge N → pc_miss_sgn=1 and pc_in valid from N+1, held constant.
- Refill completion:
  - finish_ins sampled at edge M → pc_miss_sgn=0, ins_valid=1 and fetch_ready=1 from M+1.
  - Line readable by a hit sampled at edge M+1.
- finish_ins seen outside REFILL: ignored.
- flush and finish_ins on the same edge: line installed, no ins_valid.
- Reset asserted mid-refill: immediate return to IDLE and pc_miss_sgn drops asynchronously. The memory controller shares this reset.
- rdy low: no edge has effect; ins_valid, if high, stays high until rdy returns.

## Configuration
- ICACHE_PERF_CNT_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt increments on each accepted hit; miss_cnt on each REFILL entry.
  - Counters include flushed requests and wrap at 2^32.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Cold miss: fetch_pc=0x0000_1044 after reset → pc_miss_sgn=1, pc_in=0x0000_1040. Model responds with finish_ins and word1=0xDEADBEEF → ins_valid one cycle, ins=0xDEADBEEF, pc_miss_sgn low the same cycle.
- Hit streaming: after that fill, requests 0x1040..0x107C on consecutive cycles → 16 consecutive ins_valid pulses, 1-cycle latency each, no pc_miss_sgn.
- Conflict eviction (INDEX_BITS=4): fill 0x0000_1040, then fetch 0x0000_1440 (same index, different tag) → refill; a fetch of 0x1040 afterwards misses again.
- Flush during refill: miss on 0x2000, flush pulsed while waiting, then finish_ins → no ins_valid; a following fetch of 0x2004 hits with 1-cycle latency.
- Async reset mid-refill: drop rst two cycles into REFILL → pc_miss_sgn=0 immediately, fetch_ready=1; after release a previously cached PC misses.
- rdy stall: rdy=0 for 3 cycles with a hit pending → ins_valid held; no state change; completes normally when rdy=1.
